// File: rtl/bp_pkg.sv
// Shared branch-predictor types: table geometry, counter reset value, FSM states.
// Also holds the saturating counter update used by both the table and the bypass path.
package bp_pkg;
  localparam int HIST_W = 12;
  localparam int CTR_W  = 2;
  localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;

  typedef enum logic {INIT, RUN} state_t;

  function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                   input logic            taken);
    if (taken) return (&ctr) ? ctr : ctr + 1'b1;
    else       return (|ctr) ? ctr - 1'b1 : ctr;
  endfunction
endpackage

// File: rtl/global_predictor_if.sv
// Lookup/update bus of the global predictor; master is the fetch/resolve side.
// No backpressure: Ready only gates acceptance during table initialisation.
interface global_predictor_if #(
  parameter int HIST_W = bp_pkg::HIST_W,
  parameter int CTR_W  = bp_pkg::CTR_W
);
  logic [HIST_W-1:0] PHistory;
  logic              PredictReq;
  logic              Prediction;
  logic [CTR_W-1:0]  PredictCounter;
  logic              PredictValid;
  logic              UpdateEn;
  logic [HIST_W-1:0] UpdateIndex;
  logic              UpdateTaken;
  logic              Ready;

  modport master (
    output PHistory, PredictReq, UpdateEn, UpdateIndex, UpdateTaken,
    input  Prediction, PredictCounter, PredictValid, Ready
  );

  modport slave (
    input  PHistory, PredictReq, UpdateEn, UpdateIndex, UpdateTaken,
    output Prediction, PredictCounter, PredictValid, Ready
  );
endinterface

// File: rtl/predictor_table.sv
// Counter storage: one write port (init load or saturating read-modify-write), one
// combinational read port; writes land at the clock edge, no reset on the array.
module predictor_table import bp_pkg::*; #(
  parameter int HIST_W = bp_pkg::HIST_W,
  parameter int CTR_W  = bp_pkg::CTR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic              wr_init,
  input  logic [HIST_W-1:0] wr_idx,
  input  logic              wr_taken,
  input  logic [HIST_W-1:0] rd_idx,
  output logic [CTR_W-1:0]  rd_ctr
);
  logic [CTR_W-1:0] mem [2**HIST_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_init ? CTR_INIT : sat_update(mem[wr_idx], wr_taken);
  end

  assign rd_ctr = mem[rd_idx];
endmodule

// File: rtl/global_predictor.sv
// Global-history direction predictor: INIT sweep, then 1-cycle lookups and in-place updates.
// Lookup latency 1 cycle; requests and updates arriving before Ready are dropped.
module global_predictor import bp_pkg::*; #(
  parameter int HIST_W = bp_pkg::HIST_W,
  parameter int CTR_W  = bp_pkg::CTR_W
) (
  input logic               clock,
  input logic               reset,
  global_predictor_if.slave bus
);
  state_t            state, state_nxt;
  logic [HIST_W-1:0] sweep, sweep_nxt;
  logic              tbl_wr_en;
  logic              tbl_wr_init;
  logic [HIST_W-1:0] tbl_wr_idx;
  logic [CTR_W-1:0]  tbl_rd_ctr;
  logic [CTR_W-1:0]  lookup_ctr;
  logic [CTR_W-1:0]  pred_ctr;
  logic              pred_vld;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sweep_nxt   = sweep;
    tbl_wr_en   = 1'b0;
    tbl_wr_init = 1'b0;
    tbl_wr_idx  = bus.UpdateIndex;
    case (state)
      INIT: begin
        tbl_wr_en   = 1'b1;
        tbl_wr_init = 1'b1;
        tbl_wr_idx  = sweep;
        sweep_nxt   = sweep + 1'b1;
        if (&sweep) state_nxt = RUN;
      end
      RUN:     tbl_wr_en = bus.UpdateEn;
      default: state_nxt = INIT;
    endcase
  end

  predictor_table #(.HIST_W(HIST_W), .CTR_W(CTR_W)) u_table (
    .clock    (clock),
    .wr_en    (tbl_wr_en),
    .wr_init  (tbl_wr_init),
    .wr_idx   (tbl_wr_idx),
    .wr_taken (bus.UpdateTaken),
    .rd_idx   (bus.PHistory),
    .rd_ctr   (tbl_rd_ctr)
  );

  // A same-index update this cycle is forwarded so the lookup sees the post-update counter.
  always_comb begin
    lookup_ctr = tbl_rd_ctr;
    if (bus.UpdateEn && (bus.UpdateIndex == bus.PHistory))
      lookup_ctr = sat_update(tbl_rd_ctr, bus.UpdateTaken);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pred_vld <= 1'b0;
      pred_ctr <= '0;
    end else begin
      pred_vld <= (state == RUN) && bus.PredictReq;
      if ((state == RUN) && bus.PredictReq) pred_ctr <= lookup_ctr;
    end
  end

  assign bus.PredictValid   = pred_vld;
  assign bus.PredictCounter = pred_ctr;
  assign bus.Prediction     = pred_ctr[CTR_W-1];
  assign bus.Ready          = (state == RUN);
endmodule

// File: doc/global_predictor.md
GLOBAL_PREDICTOR -- requirements
Module: global_predictor

Interface
REQ-001 Parameter HIST_W, default 12, path-history/index width.
REQ-002 Parameter CTR_W, default 2, saturating-counter width.
REQ-003 Ports: clock  in  1  sole clock, all state on rising edge.
REQ-004 Ports: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: PHistory  in  HIST_W  path history from the path-history register; the lookup index.
REQ-006 Ports: PredictReq  in  1  lookup request for PHistory this cycle.
REQ-007 Ports: Prediction  out  1  predicted direction (1 = taken).
REQ-008 Ports: PredictCounter  out  CTR_W  counter value behind Prediction.
REQ-009 Ports: PredictValid  out  1  Prediction/PredictCounter valid this cycle.
REQ-010 Ports: UpdateEn  in  1  resolved-branch update strobe.
REQ-011 Ports: UpdateIndex  in  HIST_W  index captured at prediction time.
REQ-012 Ports: UpdateTaken  in  1  resolved outcome.
REQ-013 Ports: Ready  out  1  table initialised; lookups and updates are accepted.

Function
REQ-014 Table SHALL hold 2**HIST_W counters of CTR_W bits.
REQ-015 FSM SHALL have two states, INIT and RUN; reset forces INIT with sweep counter 0.
REQ-016 INIT SHALL write CTR_INIT (2'b01, weakly not-taken) to one entry per cycle at indices 0..2**HIST_W-1.
REQ-017 INIT SHALL go to RUN on the cycle after index 2**HIST_W-1 is written, i.e. 4096 cycles after reset release.
REQ-018 Ready SHALL be 1 only in RUN.
REQ-019 In INIT, PredictReq and UpdateEn SHALL be ignored: no table write, and PredictValid stays 0.
REQ-020 Latency SHALL be one cycle: a PredictReq in RUN at cycle N gives PredictValid=1 at N+1, with PredictCounter = table[PHistory sampled at N] and Prediction = PredictCounter MSB.
REQ-021 PredictValid SHALL be 0 in any cycle that does not follow an accepted PredictReq; Prediction and PredictCounter SHALL hold their last values.
REQ-022 An UpdateEn in RUN at cycle N SHALL write table[UpdateIndex] at the end of N.
REQ-023 Update arithmetic SHALL increment on taken and saturate at 2'b11, and decrement on not-taken and saturate at 2'b00.
REQ-024 When PredictReq and UpdateEn occur in the same cycle with PHistory == UpdateIndex, the prediction SHALL return the post-update value (write-through bypass).
REQ-025 Back-to-back updates to one index SHALL each apply; the second SHALL see the first's result.
REQ-026 Updates and lookups to different indices in the same cycle SHALL be independent.

Reset
REQ-027 While reset=1: state INIT, sweep counter 0, Ready=0, PredictValid=0, Prediction=0, PredictCounter=0.
REQ-028 Table contents SHALL NOT need a reset; the INIT sweep defines them.
REQ-029 Reset asserted mid-sweep or in RUN SHALL restart the full sweep from index 0.

Structure
REQ-030 Shared package bp_pkg SHALL hold HIST_W, CTR_W, CTR_INIT, the state enum {INIT, RUN} and the saturating-update function.
REQ-031 Storage SHALL be the sub-module predictor_table: 2**HIST_W x CTR_W, one synchronous write port and one read port.
REQ-032 FSM, bypass and output registers SHALL reside in global_predictor.

Verification
REQ-033 Reset held 3 cycles, then released -> Ready=0 for 4096 cycles, then 1; lookups of indices 0x000 and 0xFFF -> PredictCounter=01, Prediction=0.
REQ-034 Three taken updates to 0x0A5, then a lookup of 0x0A5 -> counter 10, then 11, then 11 (saturated); Prediction=1 one cycle after PredictReq.
REQ-035 Three not-taken updates to 0xFFF, then a lookup -> counter 00 (saturated), Prediction=0.
REQ-036 Same-cycle PredictReq at PHistory=0x123 and taken UpdateEn at 0x123, starting from 01 -> next cycle PredictCounter=10, Prediction=1, PredictValid=1.
REQ-037 Reset pulsed at sweep count 2000, and UpdateEn applied to 0x010 during INIT -> Ready stays 0 for a full 4096 cycles after release; a lookup of 0x010 then returns 01.
